// File: rtl/mem_stage.sv
// Memory pipeline stage: aligns and zero-extends load data, splits misaligned
// word/half accesses into a second beat, and registers the MEM/WB fields.
module mem_stage #(
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        bubble_in,
  input  logic [4:0]  opcode_in,
  input  logic [4:0]  tgt_in_1,
  input  logic [4:0]  tgt_in_2,
  input  logic [31:0] result_in_1,
  input  logic [31:0] result_in_2,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  input  logic        is_load_in,
  input  logic        is_store_in,
  input  logic        halt_in,
  input  logic [31:0] dmem_rdata,
  input  logic [31:0] fix_rdata,
  output logic [31:0] fix_addr,
  output logic        fix_re,
  output logic        fix_we,
  output logic [3:0]  fix_be,
  output logic [31:0] fix_wdata,
  output logic        mem_stall,
  output logic [4:0]  mem_tgt_1,
  output logic [4:0]  mem_tgt_2,
  output logic [31:0] mem_result_out_1,
  output logic [31:0] mem_result_out_2,
  output logic [4:0]  mem_opcode_out,
  output logic        mem_bubble,
  output logic        is_load_mem,
  output logic        halt_out
);

  typedef enum logic {
    IDLE,
    FIX
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_firstBuf;
  logic [4:0]  r_tgt1;
  logic [4:0]  r_tgt2;
  logic [31:0] r_result1;
  logic [31:0] r_result2;
  logic [4:0]  r_opcode;
  logic        r_bubble;
  logic        r_isLoad;
  logic        r_haltOut;

  logic        w_isWord;
  logic        w_isHalf;
  logic        w_isByte;
  logic [1:0]  w_off;
  logic        w_misaligned;
  logic [31:0] w_sizeMask;
  logic [31:0] w_alignedLoad;
  logic [31:0] w_splitLoad;
  logic [31:0] w_loadValue;
  logic [3:0]  w_spillBe;
  logic [31:0] w_spillData;
  logic        w_startSplit;
  logic        w_loadBubble;

  assign w_isWord = (opcode_in >= 5'd3) && (opcode_in <= 5'd5);
  assign w_isHalf = (opcode_in >= 5'd6) && (opcode_in <= 5'd8);
  assign w_isByte = (opcode_in >= 5'd9) && (opcode_in <= 5'd11);

  // With splitting disabled the low address bits are forced to the natural alignment.
  always_comb begin
    w_off = addr_in[1:0];
    if (!MISALIGN_EN) begin
      if (w_isWord) w_off = 2'b00;
      else if (w_isHalf) w_off = {addr_in[1], 1'b0};
    end
  end

  assign w_misaligned = MISALIGN_EN && !bubble_in && (is_load_in || is_store_in) &&
                        ((w_isWord && (w_off != 2'b00)) || (w_isHalf && (w_off == 2'b11)));

  always_comb begin
    w_sizeMask = 32'hffff_ffff;
    if (w_isHalf) w_sizeMask = 32'h0000_ffff;
    else if (w_isByte) w_sizeMask = 32'h0000_00ff;
  end

  assign w_alignedLoad = (dmem_rdata >> {w_off, 3'b000}) & w_sizeMask;
  assign w_splitLoad   = 32'(({fix_rdata, r_firstBuf} >> {w_off, 3'b000})) & w_sizeMask;
  assign w_loadValue   = (r_state == FIX) ? w_splitLoad : w_alignedLoad;

  // Lanes shifted past byte 3 are the ones the second beat has to write.
  assign w_spillBe   = 4'(((w_isWord ? 8'h0f : 8'h03) << w_off) >> 4);
  assign w_spillData = store_data_in >> (6'd32 - {1'b0, w_off, 3'b000});

  assign fix_addr = {addr_in[31:2], 2'b00} + 32'd4;

  assign w_startSplit = (r_state == IDLE) && w_misaligned && !rst && !halt;
  assign w_loadBubble = bubble_in || w_startSplit;

  always_comb begin
    w_nextState = r_state;
    mem_stall   = 1'b0;
    fix_re      = 1'b0;
    fix_we      = 1'b0;
    fix_be      = 4'b0000;
    fix_wdata   = 32'h0000_0000;
    case (r_state)
      IDLE: begin
        if (w_startSplit) begin
          mem_stall   = 1'b1;
          fix_re      = is_load_in;
          fix_we      = is_store_in && !r_haltOut;
          if (fix_we) begin
            fix_be    = w_spillBe;
            fix_wdata = w_spillData;
          end
          w_nextState = FIX;
        end
      end
      FIX: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // The stall cycle loads a bubble; the held instruction registers during FIX.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_firstBuf <= 32'h0000_0000;
      r_tgt1     <= 5'd0;
      r_tgt2     <= 5'd0;
      r_result1  <= 32'h0000_0000;
      r_result2  <= 32'h0000_0000;
      r_opcode   <= 5'd0;
      r_bubble   <= 1'b1;
      r_isLoad   <= 1'b0;
      r_haltOut  <= 1'b0;
    end else if (!halt) begin
      r_state <= w_nextState;
      if (w_startSplit) r_firstBuf <= dmem_rdata;
      if (w_loadBubble) begin
        r_tgt1    <= 5'd0;
        r_tgt2    <= 5'd0;
        r_result1 <= 32'h0000_0000;
        r_result2 <= 32'h0000_0000;
        r_opcode  <= 5'd0;
        r_bubble  <= 1'b1;
        r_isLoad  <= 1'b0;
        r_haltOut <= 1'b0;
      end else begin
        r_tgt1    <= tgt_in_1;
        r_tgt2    <= tgt_in_2;
        r_result1 <= is_load_in ? w_loadValue : result_in_1;
        r_result2 <= result_in_2;
        r_opcode  <= opcode_in;
        r_bubble  <= 1'b0;
        r_isLoad  <= is_load_in;
        r_haltOut <= halt_in;
      end
    end
  end

  assign mem_tgt_1        = r_tgt1;
  assign mem_tgt_2        = r_tgt2;
  assign mem_result_out_1 = r_result1;
  assign mem_result_out_2 = r_result2;
  assign mem_opcode_out   = r_opcode;
  assign mem_bubble       = r_bubble;
  assign is_load_mem      = r_isLoad;
  assign halt_out         = r_haltOut;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: aligned loads, split loads/stores,
// reset inside the split, halt freezing and halt-instruction suppression.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic        bubble_in;
  logic [4:0]  opcode_in;
  logic [4:0]  tgt_in_1;
  logic [4:0]  tgt_in_2;
  logic [31:0] result_in_1;
  logic [31:0] result_in_2;
  logic [31:0] addr_in;
  logic [31:0] store_data_in;
  logic        is_load_in;
  logic        is_store_in;
  logic        halt_in;
  logic [31:0] dmem_rdata;
  logic [31:0] fix_rdata;
  logic [31:0] fix_addr;
  logic        fix_re;
  logic        fix_we;
  logic [3:0]  fix_be;
  logic [31:0] fix_wdata;
  logic        mem_stall;
  logic [4:0]  mem_tgt_1;
  logic [4:0]  mem_tgt_2;
  logic [31:0] mem_result_out_1;
  logic [31:0] mem_result_out_2;
  logic [4:0]  mem_opcode_out;
  logic        mem_bubble;
  logic        is_load_mem;
  logic        halt_out;

  int assertCount = 0;
  int failCount = 0;

  mem_stage #(.MISALIGN_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .halt(halt), .bubble_in(bubble_in), .opcode_in(opcode_in),
    .tgt_in_1(tgt_in_1), .tgt_in_2(tgt_in_2), .result_in_1(result_in_1), .result_in_2(result_in_2),
    .addr_in(addr_in), .store_data_in(store_data_in), .is_load_in(is_load_in), .is_store_in(is_store_in),
    .halt_in(halt_in), .dmem_rdata(dmem_rdata), .fix_rdata(fix_rdata), .fix_addr(fix_addr),
    .fix_re(fix_re), .fix_we(fix_we), .fix_be(fix_be), .fix_wdata(fix_wdata), .mem_stall(mem_stall),
    .mem_tgt_1(mem_tgt_1), .mem_tgt_2(mem_tgt_2), .mem_result_out_1(mem_result_out_1),
    .mem_result_out_2(mem_result_out_2), .mem_opcode_out(mem_opcode_out), .mem_bubble(mem_bubble),
    .is_load_mem(is_load_mem), .halt_out(halt_out)
  );

  // 10 ns clock; inputs change and outputs are sampled 1 ns after each rising edge.
  always #5 clk = ~clk;

  task tick();
    @(posedge clk);
    #1;
  endtask

  task setBubble();
    bubble_in = 1'b1; opcode_in = 5'd0; tgt_in_1 = 5'd0; tgt_in_2 = 5'd0;
    result_in_1 = 32'h0; result_in_2 = 32'h0; addr_in = 32'h0; store_data_in = 32'h0;
    is_load_in = 1'b0; is_store_in = 1'b0; halt_in = 1'b0;
  endtask

  task applyStimulus(input logic [4:0] op, input logic [31:0] addr, input logic ld, input logic st,
                     input logic [31:0] sdata, input logic [4:0] t1, input logic [31:0] r1);
    bubble_in = 1'b0; opcode_in = op; tgt_in_1 = t1; tgt_in_2 = t1 + 5'd1;
    result_in_1 = r1; result_in_2 = addr + 32'd4; addr_in = addr; store_data_in = sdata;
    is_load_in = ld; is_store_in = st; halt_in = 1'b0;
  endtask

  task test_reset();
    rst = 1'b1; halt = 1'b0; setBubble(); dmem_rdata = 32'h0; fix_rdata = 32'h0;
    tick(); tick();
    rst = 1'b0;
    #1;
    assertCount++; if (mem_bubble !== 1'b1) begin failCount++; $display("[TB] FAIL reset_bubble: got %b expected 1", mem_bubble); end
    assertCount++; if ({mem_tgt_1, mem_tgt_2} !== 10'd0) begin failCount++; $display("[TB] FAIL reset_tgts: got %h expected 0", {mem_tgt_1, mem_tgt_2}); end
    assertCount++; if ({is_load_mem, halt_out} !== 2'b00) begin failCount++; $display("[TB] FAIL reset_flags: got %b expected 00", {is_load_mem, halt_out}); end
    assertCount++; if ({mem_result_out_1, mem_result_out_2, mem_opcode_out} !== 69'd0) begin failCount++; $display("[TB] FAIL reset_results: got %h expected 0", {mem_result_out_1, mem_result_out_2, mem_opcode_out}); end
    assertCount++; if ({fix_re, fix_we, fix_be, mem_stall} !== 7'd0) begin failCount++; $display("[TB] FAIL reset_strobes: got %b expected 0", {fix_re, fix_we, fix_be, mem_stall}); end
  endtask

  task test_aligned_load();
    applyStimulus(5'd3, 32'h100, 1'b1, 1'b0, 32'h0, 5'd5, 32'h0);
    dmem_rdata = 32'hAABBCCDD;
    #1;
    assertCount++; if ({mem_stall, fix_re} !== 2'b00) begin failCount++; $display("[TB] FAIL lw_aligned_nostall: got %b expected 00", {mem_stall, fix_re}); end
    tick();
    assertCount++; if (mem_result_out_1 !== 32'hAABBCCDD) begin failCount++; $display("[TB] FAIL lw_result: got %h expected aabbccdd", mem_result_out_1); end
    assertCount++; if ({is_load_mem, mem_bubble, mem_tgt_1, mem_tgt_2} !== {1'b1, 1'b0, 5'd5, 5'd6}) begin failCount++; $display("[TB] FAIL lw_fields: got %b %b %0d %0d expected 1 0 5 6", is_load_mem, mem_bubble, mem_tgt_1, mem_tgt_2); end
    assertCount++; if ({mem_result_out_2, mem_opcode_out} !== {32'h104, 5'd3}) begin failCount++; $display("[TB] FAIL lw_result2_opcode: got %h %0d expected 104 3", mem_result_out_2, mem_opcode_out); end
    // Non-load passes result_in_1 straight through.
    applyStimulus(5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd12, 32'h12345678);
    tick();
    assertCount++; if ({mem_result_out_1, is_load_mem} !== {32'h12345678, 1'b0}) begin failCount++; $display("[TB] FAIL alu_passthru: got %h %b expected 12345678 0", mem_result_out_1, is_load_mem); end
    setBubble();
  endtask

  task test_byte_half_load();
    dmem_rdata = 32'hAABBCCDD;
    applyStimulus(5'd9, 32'h102, 1'b1, 1'b0, 32'h0, 5'd3, 32'h0);
    tick();
    assertCount++; if (mem_result_out_1 !== 32'h000000BB) begin failCount++; $display("[TB] FAIL lb_102: got %h expected 000000bb", mem_result_out_1); end
    applyStimulus(5'd6, 32'h101, 1'b1, 1'b0, 32'h0, 5'd4, 32'h0);
    #1;
    assertCount++; if (mem_stall !== 1'b0) begin failCount++; $display("[TB] FAIL lh_101_nostall: got %b expected 0", mem_stall); end
    tick();
    assertCount++; if (mem_result_out_1 !== 32'h0000BBCC) begin failCount++; $display("[TB] FAIL lh_101: got %h expected 0000bbcc", mem_result_out_1); end
    setBubble();
  endtask

  task test_misaligned_load();
    applyStimulus(5'd3, 32'h103, 1'b1, 1'b0, 32'h0, 5'd7, 32'h0);
    dmem_rdata = 32'h11223344; fix_rdata = 32'h0;
    #1;
    assertCount++; if ({mem_stall, fix_re, fix_we} !== 3'b110) begin failCount++; $display("[TB] FAIL lw_split_strobes: got %b expected 110", {mem_stall, fix_re, fix_we}); end
    assertCount++; if (fix_addr !== 32'h104) begin failCount++; $display("[TB] FAIL lw_split_addr: got %h expected 00000104", fix_addr); end
    tick();
    assertCount++; if ({mem_bubble, mem_tgt_1, is_load_mem} !== {1'b1, 5'd0, 1'b0}) begin failCount++; $display("[TB] FAIL lw_split_bubble: got %b %0d %b expected 1 0 0", mem_bubble, mem_tgt_1, is_load_mem); end
    dmem_rdata = 32'h0; fix_rdata = 32'h55667788;
    #1;
    assertCount++; if ({mem_stall, fix_re} !== 2'b00) begin failCount++; $display("[TB] FAIL lw_fix_nostall: got %b expected 00", {mem_stall, fix_re}); end
    tick();
    assertCount++; if ({mem_result_out_1, mem_tgt_1, is_load_mem, mem_bubble} !== {32'h66778811, 5'd7, 1'b1, 1'b0}) begin failCount++; $display("[TB] FAIL lw_split_result: got %h %0d %b %b expected 66778811 7 1 0", mem_result_out_1, mem_tgt_1, is_load_mem, mem_bubble); end
    // Half access straddling the word boundary.
    applyStimulus(5'd6, 32'h103, 1'b1, 1'b0, 32'h0, 5'd8, 32'h0);
    dmem_rdata = 32'h11223344; fix_rdata = 32'h0;
    #1;
    assertCount++; if (mem_stall !== 1'b1) begin failCount++; $display("[TB] FAIL lh_split_stall: got %b expected 1", mem_stall); end
    tick();
    fix_rdata = 32'h55667788;
    tick();
    assertCount++; if (mem_result_out_1 !== 32'h00008811) begin failCount++; $display("[TB] FAIL lh_split_result: got %h expected 00008811", mem_result_out_1); end
    setBubble();
  endtask

  task test_misaligned_store();
    applyStimulus(5'd4, 32'h102, 1'b0, 1'b1, 32'hDEADBEEF, 5'd0, 32'h55);
    #1;
    assertCount++; if ({mem_stall, fix_re, fix_we, fix_be} !== 7'b1010011) begin failCount++; $display("[TB] FAIL sw_split_strobes: got %b expected 1010011", {mem_stall, fix_re, fix_we, fix_be}); end
    assertCount++; if ({fix_wdata, fix_addr} !== {32'h0000DEAD, 32'h104}) begin failCount++; $display("[TB] FAIL sw_split_data: got %h %h expected 0000dead 00000104", fix_wdata, fix_addr); end
    tick();
    #1;
    assertCount++; if ({mem_stall, fix_we, mem_bubble} !== 3'b001) begin failCount++; $display("[TB] FAIL sw_fix_cycle: got %b expected 001", {mem_stall, fix_we, mem_bubble}); end
    tick();
    assertCount++; if ({mem_bubble, mem_result_out_1} !== {1'b0, 32'h55}) begin failCount++; $display("[TB] FAIL sw_split_result: got %b %h expected 0 00000055", mem_bubble, mem_result_out_1); end
    setBubble();
  endtask

  task test_reset_in_fix();
    applyStimulus(5'd3, 32'h103, 1'b1, 1'b0, 32'h0, 5'd10, 32'h0);
    dmem_rdata = 32'h11223344; fix_rdata = 32'h0;
    tick();
    rst = 1'b1;
    #1;
    assertCount++; if ({fix_re, fix_we, mem_stall} !== 3'b000) begin failCount++; $display("[TB] FAIL rst_fix_strobes: got %b expected 000", {fix_re, fix_we, mem_stall}); end
    tick();
    rst = 1'b0;
    #1;
    assertCount++; if ({mem_bubble, mem_tgt_1, mem_tgt_2, is_load_mem} !== {1'b1, 10'd0, 1'b0}) begin failCount++; $display("[TB] FAIL rst_fix_outputs: got %b %0d %0d %b expected 1 0 0 0", mem_bubble, mem_tgt_1, mem_tgt_2, is_load_mem); end
    assertCount++; if ({mem_stall, fix_re} !== 2'b11) begin failCount++; $display("[TB] FAIL rst_fix_back_to_idle: got %b expected 11", {mem_stall, fix_re}); end
    tick();
    fix_rdata = 32'h55667788;
    tick();
    assertCount++; if (mem_result_out_1 !== 32'h66778811) begin failCount++; $display("[TB] FAIL rst_fix_retry_result: got %h expected 66778811", mem_result_out_1); end
    setBubble();
  endtask

  task test_halt_mid_split();
    dmem_rdata = 32'hAABBCCDD;
    applyStimulus(5'd3, 32'h100, 1'b1, 1'b0, 32'h0, 5'd2, 32'h0);
    tick();
    halt = 1'b1;
    applyStimulus(5'd9, 32'h100, 1'b1, 1'b0, 32'h0, 5'd20, 32'h0);
    tick(); tick();
    assertCount++; if ({mem_result_out_1, mem_tgt_1} !== {32'hAABBCCDD, 5'd2}) begin failCount++; $display("[TB] FAIL halt_hold_valid: got %h %0d expected aabbccdd 2", mem_result_out_1, mem_tgt_1); end
    halt = 1'b0;
    applyStimulus(5'd3, 32'h103, 1'b1, 1'b0, 32'h0, 5'd9, 32'h0);
    dmem_rdata = 32'h11223344; fix_rdata = 32'h0;
    tick();
    halt = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    #1;
    assertCount++; if ({mem_stall, fix_re, fix_we} !== 3'b000) begin failCount++; $display("[TB] FAIL halt_strobes: got %b expected 000", {mem_stall, fix_re, fix_we}); end
    tick(); tick(); tick();
    assertCount++; if ({mem_bubble, mem_tgt_1, is_load_mem} !== {1'b1, 5'd0, 1'b0}) begin failCount++; $display("[TB] FAIL halt_frozen: got %b %0d %b expected 1 0 0", mem_bubble, mem_tgt_1, is_load_mem); end
    halt = 1'b0; fix_rdata = 32'h55667788;
    #1;
    assertCount++; if (mem_stall !== 1'b0) begin failCount++; $display("[TB] FAIL halt_release_state: got %b expected 0", mem_stall); end
    tick();
    assertCount++; if ({mem_result_out_1, mem_tgt_1} !== {32'h66778811, 5'd9}) begin failCount++; $display("[TB] FAIL halt_resume_result: got %h %0d expected 66778811 9", mem_result_out_1, mem_tgt_1); end
    setBubble();
  endtask

  task test_halt_instr();
    setBubble(); halt_in = 1'b1;
    tick();
    assertCount++; if (halt_out !== 1'b0) begin failCount++; $display("[TB] FAIL halt_in_bubble: got %b expected 0", halt_out); end
    applyStimulus(5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0);
    halt_in = 1'b1;
    tick();
    assertCount++; if (halt_out !== 1'b1) begin failCount++; $display("[TB] FAIL halt_out_set: got %b expected 1", halt_out); end
    applyStimulus(5'd4, 32'h102, 1'b0, 1'b1, 32'hDEADBEEF, 5'd0, 32'h0);
    #1;
    assertCount++; if ({mem_stall, fix_we} !== 2'b10) begin failCount++; $display("[TB] FAIL halt_suppress_we: got %b expected 10", {mem_stall, fix_we}); end
    tick(); tick();
    setBubble();
  endtask

  task test_bubble();
    applyStimulus(5'd3, 32'h103, 1'b1, 1'b0, 32'h0, 5'd15, 32'h0);
    bubble_in = 1'b1;
    #1;
    assertCount++; if ({mem_stall, fix_re, fix_we} !== 3'b000) begin failCount++; $display("[TB] FAIL bubble_strobes: got %b expected 000", {mem_stall, fix_re, fix_we}); end
    tick();
    assertCount++; if ({mem_bubble, mem_tgt_1, mem_tgt_2, is_load_mem} !== {1'b1, 10'd0, 1'b0}) begin failCount++; $display("[TB] FAIL bubble_outputs: got %b %0d %0d %b expected 1 0 0 0", mem_bubble, mem_tgt_1, mem_tgt_2, is_load_mem); end
    setBubble();
  endtask

  task test_back_to_back();
    logic [31:0] addrs [3] = '{32'h200, 32'h201, 32'h203};
    logic [31:0] exps  [3] = '{32'hDD, 32'hCC, 32'hAA};
    dmem_rdata = 32'hAABBCCDD;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(5'd10, addrs[i], 1'b1, 1'b0, 32'h0, 5'(i + 1), 32'h0);
      tick();
      assertCount++; if ({mem_result_out_1, mem_tgt_1} !== {exps[i], 5'(i + 1)}) begin failCount++; $display("[TB] FAIL b2b_lb_%0d: got %h %0d expected %h %0d", i, mem_result_out_1, mem_tgt_1, exps[i], i + 1); end
    end
    setBubble();
    tick();
  endtask

  initial begin
    test_reset();
    test_aligned_load();
    test_byte_half_load();
    test_misaligned_load();
    test_misaligned_store();
    test_reset_in_fix();
    test_halt_mid_split();
    test_halt_instr();
    test_bubble();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
